// File: rtl/dzcpu_useq.sv
// dzcpu_useq: microprogram sequencer -- opcode fetch, LUT dispatch and micro-PC stepping.
// The CB-prefix redirect is built only when DZCPU_USEQ_CB_EN is defined.
module dzcpu_useq (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [7:0]  iMop,
    input  logic        iMopValid,
    output logic        oMopReq,
    output logic [7:0]  oLutMop,
    input  logic [7:0]  iLutIdx,
    input  logic [7:0]  iCbLutIdx,
    output logic [7:0]  oRomAddr,
    input  logic [12:0] iUop,
    output logic [12:0] oUop,
    output logic        oUopValid,
    input  logic        iStall,
    input  logic        iFlagZ,
    output logic        oPcInc,
    output logic        oFlagUpdate,
    output logic        oEof,
    output logic        oCbActive,
    output logic        oFault
);
    localparam logic [4:0] P_JCB_OP = 5'h1F;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DISPATCH,
        S_EXEC,
`ifdef DZCPU_USEQ_CB_EN
        S_CB_FETCH,
        S_CB_DISPATCH,
`endif
        S_FAULT
    } state_t;

    state_t     state, next_state;
    logic [7:0] upc, next_upc;
    logic [7:0] lut_mop;
    logic       latch_mop;
    logic       advance;
    logic [3:0] ctrl;
    logic [4:0] opf;

    assign ctrl     = iUop[12:9];
    assign opf      = iUop[8:4];
    assign oUop     = iUop;
    assign oRomAddr = upc;
    assign oLutMop  = lut_mop;
    assign oFault   = (state == S_FAULT);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        next_state  = state;
        next_upc    = upc;
        latch_mop   = 1'b0;
        advance     = 1'b0;
        oMopReq     = 1'b0;
        oUopValid   = 1'b0;
        oPcInc      = 1'b0;
        oFlagUpdate = 1'b0;
        oEof        = 1'b0;
        case (state)
            S_FETCH: begin
                oMopReq = 1'b1;
                if (iMopValid) begin
                    latch_mop  = 1'b1;
                    next_state = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                next_upc   = iLutIdx;
                next_state = S_EXEC;
            end
`ifdef DZCPU_USEQ_CB_EN
            S_CB_FETCH: begin
                oMopReq = 1'b1;
                if (iMopValid) begin
                    latch_mop  = 1'b1;
                    next_state = S_CB_DISPATCH;
                end
            end
            S_CB_DISPATCH: begin
                next_upc   = iCbLutIdx;
                next_state = S_EXEC;
            end
`endif
            S_EXEC: begin
                if (!iStall) begin
                    oUopValid = 1'b1;
                    case (ctrl)
                        4'd0, 4'd9: advance = 1'b1;
                        4'd1: begin
                            oPcInc  = 1'b1;
                            advance = 1'b1;
                        end
                        // Codes 2..5: bit 0 selects PC increment, bit 2 selects flag commit.
                        4'd2, 4'd3, 4'd4, 4'd5: begin
                            oPcInc      = ctrl[0];
                            oFlagUpdate = ctrl[2];
                            oEof        = 1'b1;
                        end
                        4'd6, 4'd7: begin
                            oPcInc = 1'b1;
                            if (iFlagZ == ~ctrl[0]) begin
                                oUopValid = 1'b0;
                                oEof      = 1'b1;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                        4'd8: begin
                            oFlagUpdate = 1'b1;
                            advance     = 1'b1;
                        end
                        default: begin
                            oUopValid  = 1'b0;
                            next_state = S_FAULT;
                        end
                    endcase
                    // The CB jump keeps only the PC-increment part of the control code.
                    if (opf == P_JCB_OP && ctrl <= 4'd9) begin
                        oFlagUpdate = 1'b0;
                        oEof        = 1'b0;
                        advance     = 1'b0;
`ifdef DZCPU_USEQ_CB_EN
                        oUopValid   = 1'b1;
                        next_state  = S_CB_FETCH;
`else
                        oUopValid   = 1'b0;
                        oPcInc      = 1'b0;
                        next_state  = S_FAULT;
`endif
                    end
                    if (oEof) begin
                        next_state = S_FETCH;
                    end
                    if (advance) begin
                        if (upc == 8'hFF) begin
                            next_state = S_FAULT;
                        end else begin
                            next_upc = upc + 8'd1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state   <= S_FETCH;
            upc     <= 8'd0;
            lut_mop <= 8'd0;
        end else begin
            state <= next_state;
            upc   <= next_upc;
            if (latch_mop) begin
                lut_mop <= iMop;
            end
        end
    end

`ifdef DZCPU_USEQ_CB_EN
    logic cb_active;
    logic unused_bits;

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            cb_active <= 1'b0;
        end else if (state == S_CB_DISPATCH) begin
            cb_active <= 1'b1;
        end else if (oEof || next_state == S_FAULT) begin
            cb_active <= 1'b0;
        end
    end

    assign oCbActive   = cb_active;
    assign unused_bits = ^iUop[3:0];
`else
    logic unused_bits;

    assign oCbActive   = 1'b0;
    assign unused_bits = ^{iUop[3:0], iCbLutIdx};
`endif

endmodule

// File: tb/tb_dzcpu_useq.sv
// Self-checking bench for dzcpu_useq: directed scenarios plus randomized flows
// scored against a flow-level model of the micro-op stream.
module tb_dzcpu_useq;
    logic        iClock = 1'b0;
    logic        iReset = 1'b1;
    logic [7:0]  iMop = 8'd0;
    logic        iMopValid = 1'b0;
    logic        oMopReq;
    logic [7:0]  oLutMop;
    logic [7:0]  iLutIdx;
    logic [7:0]  iCbLutIdx;
    logic [7:0]  oRomAddr;
    logic [12:0] iUop;
    logic [12:0] oUop;
    logic        oUopValid;
    logic        iStall = 1'b0;
    logic        iFlagZ = 1'b0;
    logic        oPcInc;
    logic        oFlagUpdate;
    logic        oEof;
    logic        oCbActive;
    logic        oFault;

    logic [12:0] rom      [256];
    logic [7:0]  main_lut [256];
    logic [7:0]  cb_lut   [256];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] addr;
        logic [3:0] st;
    } ev_t;
    ev_t exp_q[$];

    logic [3:0] strobes;
    assign strobes   = {oUopValid, oPcInc, oFlagUpdate, oEof};
    assign iUop      = rom[oRomAddr];
    assign iLutIdx   = main_lut[oLutMop];
    assign iCbLutIdx = cb_lut[oLutMop];

    always #5 iClock = ~iClock;

    dzcpu_useq dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iMop        (iMop),
        .iMopValid   (iMopValid),
        .oMopReq     (oMopReq),
        .oLutMop     (oLutMop),
        .iLutIdx     (iLutIdx),
        .iCbLutIdx   (iCbLutIdx),
        .oRomAddr    (oRomAddr),
        .iUop        (iUop),
        .oUop        (oUop),
        .oUopValid   (oUopValid),
        .iStall      (iStall),
        .iFlagZ      (iFlagZ),
        .oPcInc      (oPcInc),
        .oFlagUpdate (oFlagUpdate),
        .oEof        (oEof),
        .oCbActive   (oCbActive),
        .oFault      (oFault)
    );

    function automatic logic [12:0] w(input int c, input int op, input int opd);
        return {c[3:0], op[4:0], opd[3:0]};
    endfunction

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic to_drive();
        @(posedge iClock);
        #1;
    endtask

    task automatic to_sample();
        @(negedge iClock);
    endtask

    task automatic offer(input logic [7:0] b, output int waited);
        waited    = -1;
        iMop      = b;
        iMopValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge iClock);
            if (oMopReq === 1'b1) begin
                waited = i;
                break;
            end
            @(posedge iClock);
            #1;
        end
        to_drive();
        iMopValid = 1'b0;
    endtask

    task automatic do_reset();
        iReset    = 1'b0;
        iMopValid = 1'b0;
        iStall    = 1'b0;
        repeat (2) @(posedge iClock);
        #1;
        iReset = 1'b1;
    endtask

    // Expected micro-op events of one flow, straight from the control-code table.
    task automatic model_flow(input logic [7:0] start, input bit z);
        int  a = start;
        bit  done = 0;
        while (!done && a < 256) begin
            logic [3:0] c = rom[a][12:9];
            ev_t e;
            e.addr = a[7:0];
            case (c)
                4'd0, 4'd9: e.st = 4'b1000;
                4'd1:       e.st = 4'b1100;
                4'd8:       e.st = 4'b1010;
                4'd2: begin e.st = 4'b1001; done = 1; end
                4'd3: begin e.st = 4'b1101; done = 1; end
                4'd4: begin e.st = 4'b1011; done = 1; end
                4'd5: begin e.st = 4'b1111; done = 1; end
                4'd6, 4'd7: begin
                    if (z == (c == 4'd6)) begin
                        e.st = 4'b0101;
                        done = 1;
                    end else begin
                        e.st = 4'b1100;
                    end
                end
                default: begin e.st = 4'b0000; done = 1; end
            endcase
            exp_q.push_back(e);
            a++;
        end
    endtask

    task automatic test_reset();
        rom[0] = w(3, 0, 0);
        iMopValid = 1'b1;
        #3 iReset = 1'b0;
        #2;
        checks++;
        if ({oMopReq, strobes, oCbActive, oFault} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", {oMopReq, strobes, oCbActive, oFault}, 7'b1000000);
        end
        checks++;
        if (oRomAddr !== 8'd0 || oLutMop !== 8'd0) begin
            errors++;
            $display("FAIL reset_regs: rom_addr %0d lut_mop %0d expected 0 0", oRomAddr, oLutMop);
        end
        to_drive();
        checks++;
        if ({oMopReq, strobes} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_over_edge: got %b expected %b", {oMopReq, strobes}, 5'b10000);
        end
        iMopValid = 1'b0;
        iReset    = 1'b1;
    endtask

    task automatic test_first_flow();
        int waited;
        main_lut[0] = 8'd0;
        offer(8'h00, waited);
        checks++;
        if (waited != 0) begin
            errors++;
            $display("FAIL first_accept: waited %0d expected 0", waited);
        end
        to_sample();
        checks++;
        if ({oMopReq, strobes} !== 5'b00000) begin
            errors++;
            $display("FAIL first_dispatch: got %b expected %b", {oMopReq, strobes}, 5'b00000);
        end
        to_drive();
        to_sample();
        checks++;
        if (strobes !== 4'b1101 || oRomAddr !== 8'd0 || oUop !== rom[0]) begin
            errors++;
            $display("FAIL first_exec: strobes %b addr %0d expected 1101 addr 0", strobes, oRomAddr);
        end
        to_drive();
        to_sample();
        checks++;
        if ({oMopReq, strobes} !== 5'b10000) begin
            errors++;
            $display("FAIL first_refetch: got %b expected %b", {oMopReq, strobes}, 5'b10000);
        end
        to_drive();
    endtask

    task automatic test_stall_flow();
        int waited;
        int pc_cnt = 0;
        int eof_cnt = 0;
        logic [7:0] exp_addr [7];
        exp_addr = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd4};
        rom[1] = w(1, 3, 1);
        rom[2] = w(1, 4, 2);
        rom[3] = w(0, 5, 3);
        rom[4] = w(3, 6, 4);
        main_lut[8'h01] = 8'd1;
        offer(8'h01, waited);
        to_sample();
        to_drive();
        for (int k = 0; k < 7; k++) begin
            iStall = (k >= 1 && k <= 3);
            to_sample();
            checks++;
            if (oRomAddr !== exp_addr[k] || (iStall && strobes !== 4'b0000)) begin
                errors++;
                $display("FAIL stall_seq[%0d]: addr %0d strobes %b expected addr %0d", k, oRomAddr, strobes, exp_addr[k]);
            end
            pc_cnt  += int'(oPcInc);
            eof_cnt += int'(oEof);
            to_drive();
        end
        iStall = 1'b0;
        checks++;
        if (pc_cnt != 3 || eof_cnt != 1) begin
            errors++;
            $display("FAIL stall_counts: pc_inc %0d eof %0d expected 3 1", pc_cnt, eof_cnt);
        end
        to_sample();
        checks++;
        if (oMopReq !== 1'b1) begin
            errors++;
            $display("FAIL stall_refetch: mop_req %b expected 1", oMopReq);
        end
        to_drive();
    endtask

    task automatic test_cond_flow();
        int waited;
        int valid_cnt = 0;
        bit seen_eof = 0;
        rom[17] = w(6, 2, 0);
        rom[18] = w(0, 3, 0);
        rom[19] = w(9, 4, 0);
        rom[20] = w(2, 5, 0);
        main_lut[8'h11] = 8'd17;
        iFlagZ = 1'b1;
        offer(8'h11, waited);
        to_sample();
        to_drive();
        to_sample();
        checks++;
        if (oRomAddr !== 8'd17 || strobes !== 4'b0101) begin
            errors++;
            $display("FAIL cond_z1: addr %0d strobes %b expected 17 0101", oRomAddr, strobes);
        end
        to_drive();
        to_sample();
        checks++;
        if (oMopReq !== 1'b1) begin
            errors++;
            $display("FAIL cond_z1_refetch: mop_req %b expected 1", oMopReq);
        end
        to_drive();
        iFlagZ = 1'b0;
        offer(8'h11, waited);
        to_sample();
        to_drive();
        to_sample();
        checks++;
        if (oRomAddr !== 8'd17 || strobes !== 4'b1100) begin
            errors++;
            $display("FAIL cond_z0: addr %0d strobes %b expected 17 1100", oRomAddr, strobes);
        end
        to_drive();
        to_sample();
        checks++;
        if (oRomAddr !== 8'd18) begin
            errors++;
            $display("FAIL cond_z0_next: addr %0d expected 18", oRomAddr);
        end
        for (int k = 0; k < 6 && !seen_eof; k++) begin
            if (k > 0) to_sample();
            valid_cnt += int'(oUopValid);
            seen_eof = oEof;
            to_drive();
        end
        checks++;
        if (valid_cnt != 3 || !seen_eof) begin
            errors++;
            $display("FAIL cond_z0_tail: issued %0d eof %b expected 3 1", valid_cnt, seen_eof);
        end
    endtask

`ifdef DZCPU_USEQ_CB_EN
    task automatic test_cb_path();
        int waited;
        rom[30] = w(1, 5'h1F, 3);
        rom[16] = w(4, 2, 0);
        rom[5]  = w(2, 0, 0);
        main_lut[8'h40] = 8'd30;
        main_lut[8'h7C] = 8'd5;
        cb_lut[8'h7C]   = 8'd16;
        cb_lut[8'h40]   = 8'd99;
        offer(8'h40, waited);
        to_sample();
        to_drive();
        to_sample();
        checks++;
        if (oRomAddr !== 8'd30 || strobes !== 4'b1100 || oCbActive !== 1'b0) begin
            errors++;
            $display("FAIL cb_jump: addr %0d strobes %b cb %b expected 30 1100 0", oRomAddr, strobes, oCbActive);
        end
        to_drive();
        offer(8'h7C, waited);
        checks++;
        if (waited != 0) begin
            errors++;
            $display("FAIL cb_fetch_req: waited %0d expected 0", waited);
        end
        to_sample();
        checks++;
        if ({oMopReq, strobes} !== 5'b00000) begin
            errors++;
            $display("FAIL cb_dispatch: got %b expected %b", {oMopReq, strobes}, 5'b00000);
        end
        to_drive();
        to_sample();
        checks++;
        if (oCbActive !== 1'b1 || oRomAddr !== 8'd16 || strobes !== 4'b1011) begin
            errors++;
            $display("FAIL cb_exec: cb %b addr %0d strobes %b expected 1 16 1011", oCbActive, oRomAddr, strobes);
        end
        to_drive();
        to_sample();
        checks++;
        if (oCbActive !== 1'b0 || oMopReq !== 1'b1) begin
            errors++;
            $display("FAIL cb_exit: cb %b mop_req %b expected 0 1", oCbActive, oMopReq);
        end
        to_drive();
    endtask
`else
    task automatic test_jcb_fault();
        int waited;
        rom[30] = w(1, 5'h1F, 3);
        main_lut[8'h40] = 8'd30;
        offer(8'h40, waited);
        to_sample();
        to_drive();
        to_sample();
        checks++;
        if (strobes !== 4'b0000 || oFault !== 1'b0 || oCbActive !== 1'b0) begin
            errors++;
            $display("FAIL jcb_suppress: strobes %b fault %b cb %b expected 0000 0 0", strobes, oFault, oCbActive);
        end
        to_drive();
        to_sample();
        checks++;
        if (oFault !== 1'b1 || oMopReq !== 1'b0) begin
            errors++;
            $display("FAIL jcb_fault: fault %b mop_req %b expected 1 0", oFault, oMopReq);
        end
        to_drive();
        do_reset();
    endtask
`endif

    task automatic test_fault_reserved();
        int waited;
        rom[40] = w(4'hC, 1, 0);
        main_lut[8'h50] = 8'd40;
        offer(8'h50, waited);
        to_sample();
        to_drive();
        to_sample();
        to_drive();
        iMopValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            iStall = 1'($urandom_range(0, 1));
            to_sample();
            checks++;
            if ({oFault, oMopReq, strobes} !== 6'b100000) begin
                errors++;
                $display("FAIL fault_reserved[%0d]: got %b expected %b", k, {oFault, oMopReq, strobes}, 6'b100000);
            end
            to_drive();
        end
        do_reset();
        to_sample();
        checks++;
        if (oFault !== 1'b0 || oMopReq !== 1'b1) begin
            errors++;
            $display("FAIL fault_cleared: fault %b mop_req %b expected 0 1", oFault, oMopReq);
        end
        to_drive();
    endtask

    task automatic test_fault_overrun();
        int waited;
        rom[255] = w(0, 1, 0);
        main_lut[8'hFF] = 8'd255;
        offer(8'hFF, waited);
        to_sample();
        to_drive();
        to_sample();
        checks++;
        if (oRomAddr !== 8'd255 || oFault !== 1'b0) begin
            errors++;
            $display("FAIL overrun_exec: addr %0d fault %b expected 255 0", oRomAddr, oFault);
        end
        to_drive();
        to_sample();
        checks++;
        if (oFault !== 1'b1 || oMopReq !== 1'b0 || strobes !== 4'b0000) begin
            errors++;
            $display("FAIL overrun_fault: fault %b mop_req %b strobes %b expected 1 0 0000", oFault, oMopReq, strobes);
        end
        to_drive();
        do_reset();
    endtask

    task automatic test_reset_mid();
        int waited;
        bit found = 0;
        for (int a = 50; a < 54; a++) rom[a] = w(0, 7, a);
        rom[54] = w(2, 7, 0);
        main_lut[8'h33] = 8'd50;
        offer(8'h33, waited);
        to_sample();
        to_drive();
        for (int k = 0; k < 8; k++) begin
            to_sample();
            if (oRomAddr === 8'd52) begin
                found = 1;
                break;
            end
            to_drive();
        end
        checks++;
        if (!found || oUopValid !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach52: found %b valid %b expected 1 1", found, oUopValid);
        end
        #2 iReset = 1'b0;
        #1;
        checks++;
        if (oRomAddr !== 8'd0 || strobes !== 4'b0000 || oMopReq !== 1'b1 || oFault !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: addr %0d strobes %b mop_req %b fault %b expected 0 0000 1 0", oRomAddr, strobes, oMopReq, oFault);
        end
        to_drive();
        checks++;
        if (oRomAddr !== 8'd0 || strobes !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_hold: addr %0d strobes %b expected 0 0000", oRomAddr, strobes);
        end
        iReset = 1'b1;
    endtask

    task automatic test_random();
        localparam int NF = 40;
        int flows_done = 0;
        bit in_flow = 0;
        logic [7:0] nb = 8'($urandom);
        bit nz = 1'($urandom);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            int a = 64 + k * 24;
            int len = $urandom_range(0, 6);
            int t;
            for (int j = 0; j < len; j++) begin
                int r = $urandom_range(0, 3);
                int c = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 8 : 9;
                rom[a] = w(c, $urandom_range(0, 30), $urandom_range(0, 15));
                a++;
            end
            t = $urandom_range(2, 7);
            rom[a] = w(t, $urandom_range(0, 30), $urandom_range(0, 15));
            rom[a + 1] = w($urandom_range(2, 5), $urandom_range(0, 30), 0);
        end
        for (int i = 0; i < 256; i++) main_lut[i] = 8'(64 + (i % 8) * 24);
        for (int cyc = 0; cyc < 6000 && flows_done < NF; cyc++) begin
            iStall    = ($urandom_range(0, 2) == 0);
            iMopValid = !in_flow && ($urandom_range(0, 1) == 1);
            iMop      = nb;
            if (!in_flow) iFlagZ = nz;
            to_sample();
            if (iStall) begin
                checks++;
                if (strobes !== 4'b0000) begin
                    errors++;
                    $display("FAIL rand_stall: strobes %b expected 0000 at addr %0d", strobes, oRomAddr);
                end
            end
            if (strobes !== 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected: addr %0d strobes %b with no micro-op expected", oRomAddr, strobes);
                end else begin
                    ev_t e = exp_q.pop_front();
                    if (oRomAddr !== e.addr || strobes !== e.st || oUop !== rom[e.addr]) begin
                        errors++;
                        $display("FAIL rand_event: addr %0d strobes %b uop %h expected addr %0d strobes %b uop %h",
                                 oRomAddr, strobes, oUop, e.addr, e.st, rom[e.addr]);
                    end
                    if (e.st[0]) begin
                        in_flow = 0;
                        flows_done++;
                    end
                end
            end
            if (!in_flow && iMopValid && oMopReq === 1'b1) begin
                in_flow = 1;
                model_flow(main_lut[nb], nz);
                nb = 8'($urandom);
                nz = 1'($urandom);
            end
            to_drive();
        end
        iStall    = 1'b0;
        iMopValid = 1'b0;
        checks++;
        if (flows_done != NF || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_complete: flows %0d pending %0d expected %0d 0", flows_done, exp_q.size(), NF);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i]      = 13'd0;
            main_lut[i] = 8'd0;
            cb_lut[i]   = 8'd0;
        end
        test_reset();
        test_first_flow();
        test_stall_flow();
        test_cond_flow();
`ifdef DZCPU_USEQ_CB_EN
        test_cb_path();
`else
        test_jcb_fault();
`endif
        test_fault_reserved();
        test_fault_overrun();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
